// File: rtl/hilihase_pkg.sv
// Shared types for the HILIHASE capture path: four-state codes, capture FSM states,
// and the bridge-side event record.
package hilihase_pkg;

   localparam logic [1:0] CODE_0 = 2'd0;
   localparam logic [1:0] CODE_1 = 2'd1;
   localparam logic [1:0] CODE_X = 2'd2;
   localparam logic [1:0] CODE_Z = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } cap_state_t;

   // Event record at the default build (8 signals, 32-bit timestamp)
   localparam int unsigned EV_ID_W = 3;
   localparam int unsigned EV_TS_W = 32;

   typedef struct packed {
      logic [EV_ID_W-1:0] id;
      logic [1:0]         code;
      logic [EV_TS_W-1:0] ts;
   } hilihase_event_t;

endpackage

// File: rtl/hilihase_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered head and occupancy level.
module hilihase_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned LVL_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_q, rd_q, rd_d;
   logic [LVL_W-1:0] level_d;
   logic [WIDTH-1:0] head_d;
   logic             full, wr_en, rd_en;

   // A push into a full FIFO is accepted only when the head leaves on the same edge
   always_comb begin
      full    = (level == LVL_W'(DEPTH));
      rd_en   = pop && valid;
      wr_en   = push && (!full || rd_en);
      rd_d    = rd_en ? rd_q + AW'(1) : rd_q;
      level_d = level + LVL_W'(wr_en) - LVL_W'(rd_en);
      head_d  = (wr_en && (wr_q == rd_d)) ? din : mem[rd_d];
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_q] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         level <= '0;
         valid <= 1'b0;
         dout  <= '0;
      end else begin
         if (wr_en) begin
            wr_q <= wr_q + AW'(1);
         end
         rd_q  <= rd_d;
         level <= level_d;
         valid <= (level_d != '0);
         if (level_d != '0) begin
            dout <= head_d;
         end
      end
   end

endmodule

// File: rtl/hilihase_event_capture.sv
// Change-event recorder: detects code changes on monitored signals and queues
// timestamped {id, code, ts} events for the HILIHASE bridge.
module hilihase_event_capture
   import hilihase_pkg::*;
#(
   parameter int unsigned NUM_SIG = 8,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned TS_W    = 32,
   parameter int unsigned ID_W    = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic [2*NUM_SIG-1:0]       sig_code,
   output logic                       ev_valid,
   input  logic                       ev_ready,
   output logic [ID_W-1:0]            ev_id,
   output logic [1:0]                 ev_code,
   output logic [TS_W-1:0]            ev_ts,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       lost,
   input  logic                       clear_lost
);

   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [1:0]      code;
      logic [TS_W-1:0] ts;
   } ev_t;

   cap_state_t           state_q, state_d;
   logic                 arm, active;
   logic [TS_W-1:0]      ts_cnt;
   logic [2*NUM_SIG-1:0] shadow_q;
   logic [NUM_SIG-1:0]   pending_q, pending_d, chg, coal;
   logic [1:0]           pend_code_q [NUM_SIG];
   logic [TS_W-1:0]      pend_ts_q   [NUM_SIG];
   logic                 pick_any;
   logic [ID_W-1:0]      pick_id;
   logic [1:0]           pick_code;
   logic [TS_W-1:0]      pick_ts;
   logic                 push, pop, fifo_full, lost_set;
   ev_t                  push_ev, head_ev;

   // Capture FSM next state; detection and enqueue run only in RUN with en held
   always_comb begin
      state_d = state_q;
      arm     = 1'b0;
      active  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            arm     = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else begin
               active = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Lowest-index pending signal wins the single enqueue slot
   always_comb begin
      pick_any  = |pending_q;
      pick_id   = '0;
      pick_code = '0;
      pick_ts   = '0;
      for (int i = int'(NUM_SIG) - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            pick_id   = ID_W'(i);
            pick_code = pend_code_q[i];
            pick_ts   = pend_ts_q[i];
         end
      end
   end

   always_comb begin
      fifo_full    = (fifo_level == LVL_W'(DEPTH));
      pop          = ev_valid && ev_ready;
      push         = active && pick_any && (!fifo_full || pop);
      push_ev.id   = pick_id;
      push_ev.code = pick_code;
      push_ev.ts   = pick_ts;
   end

   // A change on a signal still pending (and not leaving this edge) coalesces
   always_comb begin
      chg       = '0;
      coal      = '0;
      pending_d = '0;
      for (int unsigned i = 0; i < NUM_SIG; i++) begin
         chg[i]       = active && (sig_code[2*i +: 2] != shadow_q[2*i +: 2]);
         coal[i]      = chg[i] && pending_q[i] && !(push && (pick_id == ID_W'(i)));
         pending_d[i] = active && (chg[i] ||
                        (pending_q[i] && !(push && (pick_id == ID_W'(i)))));
      end
      lost_set = |coal;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ts_cnt    <= '0;
         shadow_q  <= {NUM_SIG{CODE_0}};
         pending_q <= '0;
         lost      <= 1'b0;
         for (int unsigned i = 0; i < NUM_SIG; i++) begin
            pend_code_q[i] <= '0;
            pend_ts_q[i]   <= '0;
         end
      end else begin
         state_q   <= state_d;
         ts_cnt    <= ts_cnt + TS_W'(1);
         pending_q <= pending_d;
         // Unchanged signals already match, so RUN can copy the whole vector
         if (arm || active) begin
            shadow_q <= sig_code;
         end
         for (int unsigned i = 0; i < NUM_SIG; i++) begin
            if (chg[i]) begin
               pend_code_q[i] <= sig_code[2*i +: 2];
               pend_ts_q[i]   <= ts_cnt;
            end
         end
         if (lost_set) begin
            lost <= 1'b1;
         end else if (clear_lost) begin
            lost <= 1'b0;
         end
      end
   end

   hilihase_sync_fifo #(
      .WIDTH ($bits(ev_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_ev),
      .pop   (pop),
      .dout  (head_ev),
      .valid (ev_valid),
      .level (fifo_level)
   );

   assign ev_id   = head_ev.id;
   assign ev_code = head_ev.code;
   assign ev_ts   = head_ev.ts;

endmodule

// File: doc/hilihase_event_capture.md
# hilihase_event_capture

Synthesizable change-event recorder between the DUT signals and the HILIHASE bridge. It samples NUM_SIG monitored signals, each pre-encoded as a 2-bit four-state code, on every clock. Each detected change becomes a timestamped {id, code, ts} event in a FIFO. The bridge drains events over a valid/ready handshake, replacing per-signal software change callbacks with one ordered event stream.

## Interface
- NUM_SIG, 8: monitored signals, 1..32
- DEPTH, 16: event FIFO depth, power of two, ≥2
- TS_W, 32: timestamp width
- ID_W, $clog2(NUM_SIG) (min 1): event id width
- clk in 1: the only clock
- rst_n in 1: reset, asynchronous, active-low
- en in 1: capture enable
- sig_code in 2*NUM_SIG: signal i in bits [2i+1:2i]; codes 0=0, 1=1, 2=x, 3=z
- ev_valid out 1: FIFO head valid
- ev_ready in 1: bridge accepts head
- ev_id out ID_W: signal index
- ev_code out 2: new code
- ev_ts out TS_W: timestamp of the change
- fifo_level out $clog2(DEPTH)+1: occupancy
- lost out 1: sticky, at least one change coalesced away
- clear_lost in 1: clears lost

## Operation
- ts_cnt: free-running, 0 at reset, +1 every cycle, wraps 2^TS_W-1 → 0 silently.
- FSM states IDLE, ARM, RUN. Reset → IDLE.
  - IDLE, en=1 → ARM.
  - ARM: shadow ← sig_code, no events → RUN.
  - RUN, en=0 → IDLE; pending mask cleared, FIFO keeps draining.
- RUN detection per edge: for each i with sig_code[i] != shadow[i]:
  - shadow[i] ← code; pend_code[i] ← code; pend_ts[i] ← ts_cnt (pre-increment value).
  - If pending[i] is already set and not being enqueued this edge: overwrite code/ts and set lost.
  - Otherwise set pending[i].
- Enqueue: each edge, at most one event: the lowest-index pending signal, written if FIFO not full or a pop occurs on the same edge. That pending bit clears unless a new change on the same signal sets it again on that edge; that case is not lost.
- FIFO is first-word-fall-through. Pop when ev_valid && ev_ready.
- ev_id/code/ts are valid only while ev_valid; contents are don't-care otherwise.
- Full FIFO: events stay pending, and further changes coalesce (lost).
- clear_lost: lost ← 0, unless a coalesce happens on the same edge (set wins).

## Timing
- Reset values: ev_valid=0, fifo_level=0, lost=0, ev_id/code/ts=0, FSM=IDLE, pending=0, ts_cnt=0.
- en rising at edge k: ARM at k+1, RUN from k+2. Changes before the ARM edge produce no event.
- Change sampled at edge k (RUN): pending after k, written at k+1, ev_valid=1 after k+1. Latency is 2 cycles.
- N simultaneous changes: enqueued on N consecutive edges in ascending id, all with the same ev_ts.
- Sustained throughput: 1 event/cycle in and out.
- fifo_level updates on the edge of push/pop; simultaneous push+pop leaves it unchanged.
- ev_valid must not depend combinationally on ev_ready.
- Reset mid-operation: everything clears asynchronously, and in-flight events are discarded.

## Structure
- Package hilihase_pkg: code constants (CODE_0=0, CODE_1=1, CODE_X=2, CODE_Z=3), capture FSM state enum, and the event struct {id, code, ts}.
- Sub-module hilihase_sync_fifo (params WIDTH, DEPTH; FWFT, level output), reusable by the future drive-command block.
- Top level holds the FSM, shadow, pending arrays, priority pick, and ts_cnt.

## Test plan
- Reset, en=1 at cycle 2, sig_code=0 until cycle 10, then signal 3 → code 1 at edge 10 → one event {3,1,ts=10}, ev_valid from edge 11, fifo_level=1.
- Signals 0, 2, 5 change to x at the same edge 20 with ev_ready=1 → events ids 0, 2, 5 on three consecutive cycles, all ev_ts=20, code 2.
- ev_ready=0, toggle signal 1 each cycle for 20 cycles, DEPTH=16 → fifo_level saturates at 16, lost=1. Release ready → 16 in-order events then 1 coalesced event carrying the latest code. clear_lost → lost=0.
- Change at edge 30, en=0 at edge 31 before enqueue → no event. Re-enable → ARM absorbs the current values, no spurious events.
- Force ts_cnt near wrap (TS_W=4), change at count 15 and again at count 0 → ev_ts 15 then 0, order preserved.
- Assert rst_n low with 5 events queued → ev_valid, fifo_level, and lost are 0 immediately (asynchronously). After release, only new changes are reported.
